piso_serial_transmitter: RTL and testbench

//  Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready load handshake
//  and shifts it out one bit per clk on serial_out, framed by serial_valid/frame_start/serial_last.

---
 rtl/shift_pkg.sv | 10 +
 rtl/piso_serial_transmitter.sv | 144 ++++++++++++++
 tb/tb_piso_serial_transmitter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the serial shift datapaths (PISO transmitter and friends).
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/piso_serial_transmitter.sv
// Parallel-in/serial-out transmitter. Takes a WIDTH-bit word on a valid/ready
// handshake and sends it one bit per clk, framed by serial_valid, frame_start
// and serial_last. Words presented during the final bit cycle stream out with
// no gap. Define PIPO_TX_PARITY_EN to append an even-parity bit to each frame.
module piso_serial_transmitter
  import shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             serial_last,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             out_n, valid_n, start_n, last_n;
  logic             accept;
`ifdef PIPO_TX_PARITY_EN
  logic             par_q, par_n;
`endif

  // Bit that goes on the wire first from a given register image.
  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Advance the register by one bit toward the output end, zero-filling.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign busy   = (state != ST_IDLE);
  assign accept = load_valid && load_ready;

  // Ready when idle or while the final bit of the current frame is on the wire.
  always_comb begin
    load_ready = 1'b0;
    case (state)
      ST_IDLE:   load_ready = 1'b1;
`ifdef PIPO_TX_PARITY_EN
      ST_SHIFT:  load_ready = 1'b0;
      ST_PARITY: load_ready = 1'b1;
`else
      ST_SHIFT:  load_ready = (cnt == CNT_LAST);
`endif
      default:   load_ready = 1'b0;
    endcase
  end

  // Next state plus next values of the registered serial outputs.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    out_n   = 1'b0;
    valid_n = 1'b0;
    start_n = 1'b0;
    last_n  = 1'b0;
`ifdef PIPO_TX_PARITY_EN
    par_n   = par_q;
`endif
    case (state)
      ST_SHIFT: begin
        sreg_n = shift_once(sreg);
        if (cnt != CNT_LAST) begin
          cnt_n   = cnt + 1'b1;
          out_n   = first_bit(sreg_n);
          valid_n = 1'b1;
`ifndef PIPO_TX_PARITY_EN
          last_n  = (cnt_n == CNT_LAST);
`endif
        end else begin
          cnt_n = '0;
`ifdef PIPO_TX_PARITY_EN
          state_n = ST_PARITY;
          out_n   = par_q;
          valid_n = 1'b1;
          last_n  = 1'b1;
`else
          state_n = ST_IDLE;
`endif
        end
      end
      ST_PARITY: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
    // Acceptance only happens on frame boundaries, so it overrides the above.
    if (accept) begin
      state_n = ST_SHIFT;
      cnt_n   = '0;
      sreg_n  = load_data;
      out_n   = first_bit(load_data);
      valid_n = 1'b1;
      start_n = 1'b1;
      last_n  = 1'b0;
`ifdef PIPO_TX_PARITY_EN
      par_n   = ^load_data;
`endif
    end
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      sreg         <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      serial_last  <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      sreg         <= sreg_n;
      serial_out   <= out_n;
      serial_valid <= valid_n;
      frame_start  <= start_n;
      serial_last  <= last_n;
    end
  end

`ifdef PIPO_TX_PARITY_EN
  // Parity of the word captured at acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_q <= 1'b0;
    else      par_q <= par_n;
  end
`endif

endmodule

// File: tb/tb_piso_serial_transmitter.sv
// Bench for piso_serial_transmitter: one MSB-first and one LSB-first instance
// share the same stimulus and are checked against a queue-based frame model.
module tb_piso_serial_transmitter;

  localparam int W = 8;
`ifdef PIPO_TX_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic ready_m, so_m, sv_m, fs_m, sl_m, busy_m;
  logic ready_l, so_l, sv_l, fs_l, sl_l, busy_l;

  always #5 clk = ~clk;

  piso_serial_transmitter #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_m),
    .load_data(load_data), .serial_out(so_m), .serial_valid(sv_m),
    .frame_start(fs_m), .serial_last(sl_m), .busy(busy_m));

  piso_serial_transmitter #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_l),
    .load_data(load_data), .serial_out(so_l), .serial_valid(sv_l),
    .frame_start(fs_l), .serial_last(sl_l), .busy(busy_l));

  // Reference model: queue of wire bits still to appear for the current frame.
  typedef struct { logic b; logic s; logic l; } bit_t;
  bit_t qm[$];
  bit_t ql[$];

  // Table vectors: word, expected wire order for each bit order, parity bit.
  typedef struct {
    logic [7:0] data;
    logic [7:0] str_m;
    logic [7:0] str_l;
    logic       par;
  } vec_t;
  vec_t tbl[6];

  int vectors = 0;
  int miscompares = 0;

  // Explicit per-cycle expectations layered on top of the model.
  logic ex_bits_en = 1'b0, ex_frm_en = 1'b0;
  logic ex_m, ex_l, ex_start, ex_last, ex_ready;

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      qm.push_back('{d[W-1-i], i == 0, i == FRAME-1});
      ql.push_back('{d[i],     i == 0, i == FRAME-1});
    end
`ifdef PIPO_TX_PARITY_EN
    qm.push_back('{^d, 1'b0, 1'b1});
    ql.push_back('{^d, 1'b0, 1'b1});
`endif
  endtask

  task automatic model_update();
    logic rdy;
    if (!rst) begin
      qm.delete(); ql.delete();
      return;
    end
    rdy = (qm.size() <= 1);
    if (qm.size() > 0) begin
      void'(qm.pop_front()); void'(ql.pop_front());
    end
    if (load_valid && rdy) push_frame(load_data);
  endtask

  task automatic check_model();
    bit_t em, el;
    logic act;
    act = (qm.size() > 0);
    em = act ? qm[0] : '{1'b0, 1'b0, 1'b0};
    el = act ? ql[0] : '{1'b0, 1'b0, 1'b0};
    chk("m.serial_out",   so_m,    em.b);
    chk("m.serial_valid", sv_m,    act);
    chk("m.frame_start",  fs_m,    em.s);
    chk("m.serial_last",  sl_m,    em.l);
    chk("m.busy",         busy_m,  act);
    chk("m.load_ready",   ready_m, qm.size() <= 1);
    chk("l.serial_out",   so_l,    el.b);
    chk("l.serial_valid", sv_l,    act);
    chk("l.frame_start",  fs_l,    el.s);
    chk("l.serial_last",  sl_l,    el.l);
    chk("l.busy",         busy_l,  act);
    chk("l.load_ready",   ready_l, qm.size() <= 1);
    if (ex_frm_en) begin
      chk("x.frame_start", fs_m,    ex_start);
      chk("x.serial_last", sl_m,    ex_last);
      chk("x.load_ready",  ready_m, ex_ready);
    end
    if (ex_bits_en) begin
      chk("x.bit_msb", so_m, ex_m);
      chk("x.bit_lsb", so_l, ex_l);
    end
  endtask

  // One clock: check mid-cycle, then let the edge consume the inputs.
  task automatic cyc();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Load one table word from idle and check every wire bit explicitly.
  task automatic run_frame(input int idx);
    load_valid = 1'b1;
    load_data  = tbl[idx].data;
    cyc();
    load_valid = 1'b0;
    load_data  = $urandom;
    ex_bits_en = 1'b1;
    ex_frm_en  = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      if (k < W) begin
        ex_m = tbl[idx].str_m[7-k];
        ex_l = tbl[idx].str_l[7-k];
      end else begin
        ex_m = tbl[idx].par;
        ex_l = tbl[idx].par;
      end
      ex_start = (k == 0);
      ex_last  = (k == FRAME-1);
      ex_ready = (k == FRAME-1);
      cyc();
    end
    ex_bits_en = 1'b0;
    ex_frm_en  = 1'b0;
    cyc();
  endtask

  initial begin
    tbl[0] = '{8'hB2, 8'hB2, 8'h4D, 1'b0};
    tbl[1] = '{8'h07, 8'h07, 8'hE0, 1'b1};
    tbl[2] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
    tbl[3] = '{8'h81, 8'h81, 8'h81, 1'b0};
    tbl[4] = '{8'h3C, 8'h3C, 8'h3C, 1'b0};
    tbl[5] = '{8'h01, 8'h01, 8'h80, 1'b1};

    // Reset state.
    cyc();
    cyc();
    rst = 1'b1;
    cyc();

    // Single frames from idle.
    for (int i = 0; i < 6; i++) run_frame(i);

    // Back-to-back: A5 then 3C with valid held, no gap between frames.
    load_valid = 1'b1;
    load_data  = 8'hA5;
    cyc();
    load_data  = 8'h3C;
    ex_frm_en  = 1'b1;
    for (int k = 0; k < 2*FRAME; k++) begin
      load_valid = (k < FRAME);
      ex_start   = (k == 0) || (k == FRAME);
      ex_last    = (k == FRAME-1) || (k == 2*FRAME-1);
      ex_ready   = ex_last;
      cyc();
    end
    ex_frm_en = 1'b0;
    cyc();

    // Valid raised mid-frame with 5A: held off until the final bit cycle.
    load_valid = 1'b1;
    load_data  = 8'hB2;
    cyc();
    load_valid = 1'b0;
    ex_frm_en  = 1'b1;
    for (int k = 0; k < 2*FRAME; k++) begin
      if (k == 3) begin
        load_valid = 1'b1;
        load_data  = 8'h5A;
      end
      if (k == FRAME) load_valid = 1'b0;
      ex_start = (k == 0) || (k == FRAME);
      ex_last  = (k == FRAME-1) || (k == 2*FRAME-1);
      ex_ready = ex_last;
      cyc();
    end
    ex_frm_en = 1'b0;
    cyc();

    // Reset during a frame of FF, then a clean 81 frame.
    load_valid = 1'b1;
    load_data  = 8'hFF;
    cyc();
    load_valid = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    rst = 1'b0;
    #1;
    qm.delete(); ql.delete();
    chk("rst.serial_out",   so_m,    1'b0);
    chk("rst.serial_valid", sv_m,    1'b0);
    chk("rst.busy",         busy_m,  1'b0);
    chk("rst.load_ready",   ready_m, 1'b1);
    check_model();
    cyc();
    rst = 1'b1;
    run_frame(3);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        #1;
        qm.delete(); ql.delete();
        check_model();
        cyc();
        rst = 1'b1;
      end else begin
        load_valid = ($urandom_range(0, 2) != 0);
        load_data  = $urandom;
        cyc();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
